// File: rtl/instruction_prefetch_register.sv
// Instruction prefetch register: pairs immediate-carrying instructions with the
// following word and queues complete instructions for the control unit.
module instruction_prefetch_register #(
  parameter int WORD_WIDTH    = 16,
  parameter int OPCODE_WIDTH  = 7,
  parameter int OPERAND_WIDTH = 3,
  parameter int DEPTH         = 2,
  parameter int IMM_BIT       = 6,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     notReset,
  input  logic                     notFlush,
  input  logic                     inValid,
  input  logic [WORD_WIDTH-1:0]    in,
  output logic                     inReady,
  input  logic                     notNext,
  output logic                     outValid,
  output logic [OPCODE_WIDTH-1:0]  outOpcode,
  output logic [OPERAND_WIDTH-1:0] outOp0,
  output logic [OPERAND_WIDTH-1:0] outOp1,
  output logic [OPERAND_WIDTH-1:0] outOp2,
  output logic                     outHasImm,
  output logic [WORD_WIDTH-1:0]    outImm,
  output logic [CW-1:0]            outCount
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

  logic [WORD_WIDTH-1:0] word_mem_r [DEPTH];
  logic [WORD_WIDTH-1:0] imm_mem_r  [DEPTH];
  logic                  imm_flag_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  state_t                state_r;
  logic [WORD_WIDTH-1:0] pend_r;

  logic                  out_valid_s;
  logic                  deq_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  imm_word_s;
  logic                  enq_s;
  logic [WORD_WIDTH-1:0] enq_word_s;
  logic [WORD_WIDTH-1:0] enq_imm_s;
  logic [WORD_WIDTH-1:0] head_word_s;
  logic                  head_has_imm_s;

  assign out_valid_s = (count_r != {CW{1'b0}});
  assign deq_s       = out_valid_s & ~notNext;
  // Readiness depends on occupancy and consume only, never on inValid.
  assign in_ready_s  = (count_r < CW'(DEPTH)) | deq_s;
  assign accept_s    = inValid & in_ready_s;
  assign imm_word_s  = in[WORD_WIDTH-OPCODE_WIDTH+IMM_BIT];
  assign enq_s       = accept_s & ((state_r == PEND) | ~imm_word_s);
  assign enq_word_s  = (state_r == PEND) ? pend_r : in;
  assign enq_imm_s   = (state_r == PEND) ? in : {WORD_WIDTH{1'b0}};

  assign head_word_s    = out_valid_s ? word_mem_r[rd_ptr_r] : {WORD_WIDTH{1'b0}};
  assign head_has_imm_s = out_valid_s & imm_flag_r[rd_ptr_r];

  assign inReady   = in_ready_s;
  assign outValid  = out_valid_s;
  assign outCount  = count_r;
  assign outOpcode = head_word_s[WORD_WIDTH-1 -: OPCODE_WIDTH];
  assign outOp0    = head_word_s[3*OPERAND_WIDTH-1 -: OPERAND_WIDTH];
  assign outOp1    = head_word_s[2*OPERAND_WIDTH-1 -: OPERAND_WIDTH];
  assign outOp2    = head_word_s[OPERAND_WIDTH-1:0];
  assign outHasImm = head_has_imm_s;
  assign outImm    = head_has_imm_s ? imm_mem_r[rd_ptr_r] : {WORD_WIDTH{1'b0}};

  // FIFO storage, pointers, occupancy and the word-pairing assembler FSM.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_r[i] <= {WORD_WIDTH{1'b0}};
        imm_mem_r[i]  <= {WORD_WIDTH{1'b0}};
        imm_flag_r[i] <= 1'b0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      state_r  <= IDLE;
      pend_r   <= {WORD_WIDTH{1'b0}};
    end else if (!notFlush) begin
      // Branch taken: the bus word of this cycle is consumed and dropped.
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      state_r  <= IDLE;
      pend_r   <= {WORD_WIDTH{1'b0}};
    end else begin
      if (enq_s) begin
        word_mem_r[wr_ptr_r] <= enq_word_s;
        imm_mem_r[wr_ptr_r]  <= enq_imm_s;
        imm_flag_r[wr_ptr_r] <= (state_r == PEND);
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (accept_s) begin
        case (state_r)
          IDLE: begin
            if (imm_word_s) begin
              pend_r  <= in;
              state_r <= PEND;
            end else begin
              state_r <= IDLE;
            end
          end
          PEND: begin
            pend_r  <= {WORD_WIDTH{1'b0}};
            state_r <= IDLE;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule
